// File: rtl/riscv_defines.sv
// Shared core definitions: data width, the canonical NOP encoding, the default reset
// vector, and the {addr,inst} record carried by the prefetch queue.
package riscv_defines;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INST_NOP       = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_ADDR_DEF = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head read. Push and pop may coincide at any
// occupancy, including full; flush empties it and wins over a same-cycle push.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rptr_q];
   assign do_pop  = pop_i & ~empty_o;
   // A pop frees the slot the same cycle, so a full FIFO can still take a push.
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (flush_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
   end
endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues req/gnt/rvalid memory requests under a credit
// limit, and buffers returned words with their addresses in an in-order prefetch queue.
module inst_fetch_queue
   import riscv_defines::*;
#(
   parameter int          DEPTH      = 4,
   parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_ready_i
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] infl_q, infl_d, drop_q, drop_d;
   logic          run_q;
   logic [CW-1:0] q_count, a_count;
   logic          q_empty, q_full, a_empty, a_full;
   fetch_entry_t  q_head, q_wdata;
   logic [31:0]   a_head;
   logic [CW:0]   used;
   logic          issue, rsp, rsp_keep, deq;
   logic          unused_flags;

   assign unused_flags = ^{q_full, a_full, a_empty, a_count};

   always_comb begin
      // Queued plus in-flight words bound the credit, so the queue can never overflow.
      used      = {1'b0, q_count} + {1'b0, infl_q};
      mem_req_o = run_q & (used < (CW+1)'(DEPTH)) & ~jump_en_i;
      issue     = mem_req_o & mem_gnt_i;
      rsp       = mem_rvalid_i & (infl_q != '0);
      rsp_keep  = rsp & (drop_q == '0);
      deq       = inst_valid_o & inst_ready_i & ~hold_flag_i & ~jump_en_i;
      infl_d    = infl_q + CW'(issue) - CW'(rsp);
      pc_d      = pc_q;
      drop_d    = drop_q;
      if (jump_en_i) begin
         pc_d   = jump_addr_i;
         drop_d = infl_d;
      end else begin
         if (issue)            pc_d   = pc_q + 32'd4;
         if (rsp && !rsp_keep) drop_d = drop_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q   <= RESET_ADDR;
         infl_q <= '0;
         drop_q <= '0;
         run_q  <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         infl_q <= infl_d;
         drop_q <= drop_d;
         run_q  <= 1'b1;
      end
   end

   assign mem_addr_o = pc_q;
   assign q_wdata    = '{addr: a_head, inst: mem_rdata_i};

   sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_addr_q (
      .clk(clk), .rstn(rstn), .push_i(issue), .pop_i(rsp_keep), .flush_i(jump_en_i),
      .wdata_i(pc_q), .rdata_o(a_head), .full_o(a_full), .empty_o(a_empty),
      .count_o(a_count)
   );

   sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_data_q (
      .clk(clk), .rstn(rstn), .push_i(rsp_keep), .pop_i(deq), .flush_i(jump_en_i),
      .wdata_i(q_wdata), .rdata_o(q_head), .full_o(q_full), .empty_o(q_empty),
      .count_o(q_count)
   );

   assign inst_valid_o = ~q_empty;
   assign inst_o       = inst_valid_o ? q_head.inst : INST_NOP;
   assign inst_addr_o  = inst_valid_o ? q_head.addr : 32'h0;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: reset-sequence vector table, directed corner sequences and a
// randomized run against an in-order memory model and a program-order delivery model.
module tb_inst_fetch_queue;
   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic clk = 0, rstn = 0;
   logic jump_en_i = 0, hold_flag_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0, inst_ready_i = 0;
   logic [31:0] jump_addr_i = 0, mem_rdata_i = 0;
   logic mem_req_o, inst_valid_o;
   logic [31:0] mem_addr_o, inst_o, inst_addr_o;

   inst_fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(32'h0)) dut (
      .clk(clk), .rstn(rstn), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
      .hold_flag_i(hold_flag_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
      .inst_ready_i(inst_ready_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        gnt, rv;
      logic [31:0] rdata;
      logic        req;
      logic [31:0] maddr;
      logic        vld;
      logic [31:0] iaddr, inst;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   int total = 0, bad = 0;
   int cyc = 0, n_gnt = 0, ndel = 0;
   mreq_t mq[$];
   logic [31:0] exp_fetch = 0, exp_del = 0;
   // per-cycle knobs for step()
   logic jmp_k = 0, hold_k = 0, rdy_k = 0, gnt_k = 0;
   logic [31:0] jaddr_k = 0;
   int lat_k = 1;
   // sampled values and markers for directed checks
   logic s_req, s_valid;
   logic [31:0] s_iaddr;
   logic want_g = 0, want_d = 0, seen_wrap = 0;
   logic [31:0] g_first = 0, d_first = 0;

   function automatic logic [31:0] f(input logic [31:0] a);
      return a ^ 32'h5A5A_0001;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_req", {31'b0, mem_req_o}, 0);
      chk("rst_valid", {31'b0, inst_valid_o}, 0);
      chk("rst_inst", inst_o, NOP);
      chk("rst_iaddr", inst_addr_o, 32'h0);
   endtask

   // Asynchronous reset, asserted away from the clock edge, then released at a negedge.
   task automatic do_reset();
      #3;
      rstn = 0;
      {jump_en_i, hold_flag_i, mem_gnt_i, mem_rvalid_i, inst_ready_i} = '0;
      #1;
      chk_reset_outputs();
      mq.delete();
      exp_fetch = 0;
      exp_del   = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1;
   endtask

   // One bus cycle: drive knobs and the memory model, then check against program order.
   task automatic step();
      logic grant, deliver;
      @(negedge clk);
      jump_en_i    = jmp_k;
      jump_addr_i  = jaddr_k;
      hold_flag_i  = hold_k;
      inst_ready_i = rdy_k;
      mem_gnt_i    = gnt_k;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         mem_rvalid_i = 1;
         mem_rdata_i  = f(mq[0].addr);
      end else begin
         mem_rvalid_i = 0;
         mem_rdata_i  = $urandom;
      end
      #1;
      s_req   = mem_req_o;
      s_valid = inst_valid_o;
      s_iaddr = inst_addr_o;
      grant   = mem_req_o & mem_gnt_i;
      deliver = inst_valid_o & inst_ready_i & ~hold_flag_i & ~jump_en_i;
      if (!inst_valid_o) chk("nop_when_empty", inst_o, NOP);
      if (jump_en_i) chk("req_low_on_jump", {31'b0, mem_req_o}, 0);
      if (grant) begin
         chk("fetch_addr", mem_addr_o, exp_fetch);
         exp_fetch += 4;
         n_gnt++;
         if (want_g) begin g_first = mem_addr_o; want_g = 0; end
         mq.push_back('{addr: mem_addr_o, due: cyc + lat_k});
      end
      if (deliver) begin
         chk("inst_addr", inst_addr_o, exp_del);
         chk("inst_data", inst_o, f(exp_del));
         exp_del += 4;
         ndel++;
         if (want_d) begin d_first = inst_addr_o; want_d = 0; end
         if (inst_addr_o == 32'h0) seen_wrap = 1;
      end
      if (mem_rvalid_i) void'(mq.pop_front());
      if (jump_en_i) begin
         exp_fetch = jump_addr_i;
         exp_del   = jump_addr_i;
      end
      chk("outstanding_le_depth", (mq.size() <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
      cyc++;
      @(posedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[6];
      int ng0, nd0;
      logic [31:0] hold_addr;
      tbl[0] = '{1, 0, 32'h0,      1, 32'h00, 0, 32'h0, NOP};
      tbl[1] = '{1, 1, f(32'h00),  1, 32'h04, 0, 32'h0, NOP};
      tbl[2] = '{1, 1, f(32'h04),  1, 32'h08, 1, 32'h0, f(32'h00)};
      tbl[3] = '{1, 1, f(32'h08),  1, 32'h0C, 1, 32'h4, f(32'h04)};
      tbl[4] = '{1, 1, f(32'h0C),  1, 32'h10, 1, 32'h8, f(32'h08)};
      tbl[5] = '{0, 1, f(32'h10),  1, 32'h14, 1, 32'hC, f(32'h0C)};

      // Reset state, then the back-to-back fetch table
      #1;
      chk_reset_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         mem_gnt_i    = tbl[i].gnt;
         mem_rvalid_i = tbl[i].rv;
         mem_rdata_i  = tbl[i].rdata;
         inst_ready_i = 1;
         #1;
         chk($sformatf("tbl%0d_req", i), {31'b0, mem_req_o}, {31'b0, tbl[i].req});
         chk($sformatf("tbl%0d_maddr", i), mem_addr_o, tbl[i].maddr);
         chk($sformatf("tbl%0d_valid", i), {31'b0, inst_valid_o}, {31'b0, tbl[i].vld});
         chk($sformatf("tbl%0d_iaddr", i), inst_addr_o, tbl[i].iaddr);
         chk($sformatf("tbl%0d_inst", i), inst_o, tbl[i].inst);
         @(posedge clk);
      end

      // Stalled consumer: credits stop fetching at DEPTH, then drain and resume at 0x10
      do_reset();
      rdy_k = 0; gnt_k = 1; lat_k = 1;
      ng0 = n_gnt;
      run(10);
      chk("t2_gnt_count", n_gnt - ng0, DEPTH);
      chk("t2_req_low", {31'b0, s_req}, 0);
      rdy_k = 1; want_g = 1; nd0 = ndel;
      run(12);
      chk("t2_drained", (ndel - nd0 >= 4) ? 32'd1 : 32'd0, 32'd1);
      chk("t2_resume_addr", g_first, 32'h10);

      // Jump with words both queued and in flight
      do_reset();
      rdy_k = 0; gnt_k = 1; lat_k = 1;
      run(2);
      lat_k = 10;
      run(3);
      jmp_k = 1; jaddr_k = 32'h100; gnt_k = 0;
      run(1);
      jmp_k = 0; gnt_k = 1; lat_k = 1; rdy_k = 1; want_d = 1; nd0 = ndel;
      run(25);
      chk("t3_delivered", (ndel - nd0 > 0) ? 32'd1 : 32'd0, 32'd1);
      chk("t3_first_after_jump", d_first, 32'h100);

      // Jump coinciding with gnt and rvalid
      do_reset();
      rdy_k = 1; gnt_k = 1; lat_k = 1;
      run(6);
      jmp_k = 1; jaddr_k = 32'h200;
      run(1);
      jmp_k = 0; want_d = 1;
      run(10);
      chk("t4_first_after_jump", d_first, 32'h200);

      // Hold keeps the head stable while fetching continues
      run(4);
      hold_k = 1;
      run(1);
      hold_addr = s_iaddr;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_hold_valid", {31'b0, s_valid}, 1);
         chk("t5_hold_addr", s_iaddr, hold_addr);
      end
      hold_k = 0;
      run(10);

      // PC wrap through zero, then asynchronous reset mid-transfer
      jmp_k = 1; jaddr_k = 32'hFFFF_FFF8;
      run(1);
      jmp_k = 0; want_d = 1; seen_wrap = 0;
      run(12);
      chk("t6_first_wrap", d_first, 32'hFFFF_FFF8);
      chk("t6_seen_zero", {31'b0, seen_wrap}, 1);
      do_reset();
      want_d = 1;
      run(8);
      chk("t6_refetch_reset", d_first, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         gnt_k   = ($urandom % 4) != 0;
         lat_k   = 1 + ($urandom % 4);
         rdy_k   = ($urandom % 4) != 0;
         hold_k  = ($urandom % 5) == 0;
         jmp_k   = ($urandom % 40) == 0;
         jaddr_k = {$urandom, 2'b00} >> 0;
         jaddr_k[1:0] = 2'b00;
         step();
      end
      jmp_k = 0; hold_k = 0; rdy_k = 1;
      run(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
